demux_route_sequencer: RTL and testbench



---
 rtl/demux_route_sequencer_pkg.sv | 26 ++
 rtl/demux_route_sequencer_if.sv | 19 +
 rtl/demux_route_sequencer_req_fifo.sv | 55 +++++
 rtl/demux_route_sequencer.sv | 120 ++++++++++++
 tb/tb_demux_route_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_route_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// demux_seq_pkg : shared types and constants for the demux route sequencer
// Revision 1.0
// ============================================================================
package demux_seq_pkg;

    localparam int CHAN_W       = 4;
    localparam int NUM_CHAN     = 16;
    localparam int DFLT_DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRIVE = 2'd2,
        GAP   = 2'd3
    } state_t;

    // The dwell field is sized for the default DWELL_W of the top level.
    typedef struct packed {
        logic [CHAN_W-1:0]       chan;
        logic [DFLT_DWELL_W-1:0] dwell;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/demux_route_sequencer_if.sv
`default_nettype none
// ============================================================================
// demux_route_sequencer_if : valid/ready routing-request channel
// Revision 1.0
// ============================================================================
interface demux_route_sequencer_if #(
    parameter int DWELL_W = 8
) ();
    import demux_seq_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [CHAN_W-1:0]     req_chan;
    logic [DWELL_W-1:0]    req_dwell;

    modport master (output req_valid, req_chan, req_dwell, input req_ready);
    modport slave  (input req_valid, req_chan, req_dwell, output req_ready);
endinterface
`default_nettype wire

// File: rtl/demux_route_sequencer_req_fifo.sv
`default_nettype none
// ============================================================================
// req_fifo : synchronous request FIFO with occupancy count
// Revision 1.0
// ============================================================================
module req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         data_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic      [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             w_wr, w_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    // A full queue refuses pushes even when a pop happens on the same edge.
    assign w_wr    = push_i && !full_o;
    assign w_rd    = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/demux_route_sequencer.sv
`default_nettype none
// ============================================================================
// demux_route_sequencer : queues routing requests and steers a 1x16 demux
// Revision 1.0
// ============================================================================
module demux_route_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DWELL_W    = DFLT_DWELL_W,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    demux_route_sequencer_if.slave             req,
    input  wire logic                          auto_scan,
    input  wire logic [DWELL_W-1:0]            scan_dwell,
    output logic                               i,
    output logic                               s3,
    output logic                               s2,
    output logic                               s1,
    output logic                               s0,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);
    state_t              state_q, state_d;
    req_t                cur_q, cur_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [CHAN_W-1:0]   scan_ptr_q, scan_ptr_d;
    logic [CHAN_W-1:0]   sel_q;
    logic                i_q, done_q;

    logic                w_pop, w_empty, w_full;
    logic [CHAN_W+DWELL_W-1:0] w_head;

    req_fifo #(
        .WIDTH (CHAN_W + DWELL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req.req_valid),
        .data_i  ({req.req_chan, req.req_dwell}),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full),
        .count_o (fifo_count)
    );

    assign req.req_ready = !w_full;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        scan_ptr_d = scan_ptr_q;
        w_pop      = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    cur_d   = req_t'(w_head);
                    state_d = SETUP;
                end else if (auto_scan) begin
                    cur_d.chan  = scan_ptr_q;
                    cur_d.dwell = scan_dwell;
                    scan_ptr_d  = scan_ptr_q + 1'b1;
                    state_d     = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                cnt_d   = (cur_q.dwell == '0) ? '0 : cur_q.dwell - 1'b1;
                state_d = DRIVE;
            end
            DRIVE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            scan_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            scan_ptr_q <= scan_ptr_d;
        end
    end

    // Outputs trail the state by one cycle, so the select change (SETUP slot)
    // always lands a full cycle before i rises and after i has fallen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            i_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (state_q == SETUP) sel_q <= cur_q.chan;
            i_q    <= (state_q == DRIVE);
            done_q <= (state_q == GAP);
        end
    end

    assign i    = i_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);
    assign {s3, s2, s1, s0} = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_route_sequencer.sv
`default_nettype none
// ============================================================================
// tb_demux_route_sequencer : directed, table-driven bench for the sequencer
// Revision 1.0
// ============================================================================
module tb_demux_route_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       auto_scan;
    logic [7:0] scan_dwell;
    logic       i, s3, s2, s1, s0, busy, done;
    logic [2:0] fifo_count;
    logic [3:0] sel;

    always #5 clk = ~clk;

    demux_route_sequencer_if #(.DWELL_W(8)) rif ();

    demux_route_sequencer #(.DWELL_W(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (rif),
        .auto_scan  (auto_scan),
        .scan_dwell (scan_dwell),
        .i          (i),
        .s3         (s3),
        .s2         (s2),
        .s1         (s1),
        .s0         (s0),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    assign sel = {s3, s2, s1, s0};

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Observer of the demux side: served channels, pulse widths, rule breaks.
    int         cyc = 0;
    logic       prev_i = 1'b0;
    logic [3:0] prev_sel = 4'd0;
    int         viol = 0, done_cnt = 0, max_cnt = 0, run_len = 0;
    logic [15:0] ymask = 16'd0;
    int         served_q[$], run_q[$], rise_q[$];

    always @(negedge clk) begin
        cyc++;
        if (i && prev_i && sel != prev_sel) viol++;
        if (i && !prev_i) begin
            if (sel != prev_sel) viol++;
            served_q.push_back(int'(sel));
            rise_q.push_back(cyc);
            run_len = 0;
        end
        if (i) begin
            run_len++;
            ymask |= 16'd1 << sel;
        end
        if (!i && prev_i) run_q.push_back(run_len);
        if (done) done_cnt++;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        prev_i   = i;
        prev_sel = sel;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int chan, input int dwell);
        int b = 0;
        rif.req_valid = 1'b1;
        rif.req_chan  = 4'(chan);
        rif.req_dwell = 8'(dwell);
        while (!rif.req_ready && b < 1000) begin
            tick();
            b++;
        end
        if (b >= 1000) check("push_timeout", 0, 1);
        tick();
        rif.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while ((busy || fifo_count != 0) && b < budget) begin
            tick();
            b++;
        end
        if (b >= budget) check("idle_timeout", 0, 1);
        tick(2);
    endtask

    typedef struct {
        logic       i;
        logic [3:0] sel;
        logic       done;
        logic       busy;
    } step_t;

    typedef struct {
        int chan;
        int dwell;
        int exp_run;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step_t steps[8];
        vec_t  vecs[4];
        int    d0, base, idx, bad, b;
        int    exp_order[6];
        int    exp_runs[6];

        // Timeline after a lone request chan=5 dwell=3 accepted at edge k.
        steps[1] = '{1'b0, 4'd0, 1'b0, 1'b1};
        steps[2] = '{1'b0, 4'd5, 1'b0, 1'b1};
        steps[3] = '{1'b1, 4'd5, 1'b0, 1'b1};
        steps[4] = '{1'b1, 4'd5, 1'b0, 1'b1};
        steps[5] = '{1'b1, 4'd5, 1'b0, 1'b1};
        steps[6] = '{1'b0, 4'd5, 1'b1, 1'b0};
        steps[7] = '{1'b0, 4'd5, 1'b0, 1'b0};
        steps[0] = '{1'b0, 4'd0, 1'b0, 1'b0};

        vecs[0] = '{0, 0, 1};
        vecs[1] = '{15, 2, 2};
        vecs[2] = '{7, 1, 1};
        vecs[3] = '{10, 4, 4};

        exp_order = '{1, 2, 3, 4, 5, 6};
        exp_runs  = '{255, 1, 1, 1, 1, 1};

        rst_n         = 1'b0;
        rif.req_valid = 1'b0;
        rif.req_chan  = 4'd0;
        rif.req_dwell = 8'd0;
        auto_scan     = 1'b0;
        scan_dwell    = 8'd0;
        tick(3);
        check("rst_i", int'(i), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_req_ready", int'(rif.req_ready), 1);
        rst_n = 1'b1;
        tick(2);

        // Single request: exact cycle-by-cycle timeline.
        ymask = 16'd0; d0 = done_cnt; run_q.delete();
        rif.req_valid = 1'b1; rif.req_chan = 4'd5; rif.req_dwell = 8'd3;
        tick();
        rif.req_valid = 1'b0;
        check("t1_count_after_push", int'(fifo_count), 1);
        for (int j = 1; j < 8; j++) begin
            tick();
            check($sformatf("t1_i_k+%0d", j), int'(i), int'(steps[j].i));
            check($sformatf("t1_sel_k+%0d", j), int'(sel), int'(steps[j].sel));
            check($sformatf("t1_done_k+%0d", j), int'(done), int'(steps[j].done));
            check($sformatf("t1_busy_k+%0d", j), int'(busy), int'(steps[j].busy));
        end
        check("t1_ymask", int'(ymask), 32);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_run", (run_q.size() == 1) ? run_q[0] : -1, 3);

        // Back-to-back queued requests from the vector table.
        served_q.delete(); run_q.delete(); rise_q.delete();
        d0 = done_cnt; viol = 0;
        for (int n = 0; n < 4; n++) push(vecs[n].chan, vecs[n].dwell);
        wait_idle(200);
        check("t2_served", served_q.size(), 4);
        for (int n = 0; n < 4 && n < served_q.size() && n < run_q.size(); n++) begin
            check($sformatf("t2_chan%0d", n), served_q[n], vecs[n].chan);
            check($sformatf("t2_run%0d", n), run_q[n], vecs[n].exp_run);
            if (n < 3 && n + 1 < rise_q.size())
                check($sformatf("t2_period%0d", n), rise_q[n+1] - rise_q[n], vecs[n].exp_run + 2);
        end
        check("t2_done_pulses", done_cnt - d0, 4);
        check("t2_sel_rule_violations", viol, 0);

        // Queue fill behind a long dwell.
        served_q.delete(); run_q.delete(); max_cnt = 0;
        push(1, 255);
        tick(3);
        for (int n = 2; n <= 5; n++) push(n, 1);
        check("t3_count_full", int'(fifo_count), 4);
        check("t3_ready_full", int'(rif.req_ready), 0);
        rif.req_valid = 1'b1; rif.req_chan = 4'd6; rif.req_dwell = 8'd1;
        tick(10);
        check("t3_fifth_held_count", int'(fifo_count), 4);
        check("t3_fifth_held_ready", int'(rif.req_ready), 0);
        b = 0;
        while (!rif.req_ready && b < 400) begin
            tick();
            b++;
        end
        if (b >= 400) check("t3_ready_timeout", 0, 1);
        check("t3_count_at_first_pop", int'(fifo_count), 3);
        tick();
        rif.req_valid = 1'b0;
        check("t3_count_after_fifth", int'(fifo_count), 4);
        wait_idle(600);
        check("t3_max_count", max_cnt, 4);
        check("t3_served", served_q.size(), 6);
        for (int n = 0; n < 6 && n < served_q.size() && n < run_q.size(); n++) begin
            check($sformatf("t3_chan%0d", n), served_q[n], exp_order[n]);
            check($sformatf("t3_run%0d", n), run_q[n], exp_runs[n]);
        end

        // Auto-scan sweep with one queued request injected mid-sweep.
        served_q.delete(); run_q.delete(); d0 = done_cnt; viol = 0;
        scan_dwell = 8'd1;
        auto_scan  = 1'b1;
        b = 0;
        while (served_q.size() < 20 && b < 300) begin tick(); b++; end
        push(9, 1);
        b = 0;
        while (served_q.size() < 42 && b < 400) begin tick(); b++; end
        if (b >= 400) check("t4_scan_timeout", 0, 1);
        auto_scan = 1'b0;
        wait_idle(100);
        check("t4_steps_ge_40", int'(served_q.size() >= 40), 1);
        idx = -1;
        for (int n = 0; n < served_q.size(); n++)
            if (idx < 0 && served_q[n] != n % 16) idx = n;
        check("t4_inject_pos", int'(idx >= 20 && idx < served_q.size() - 1), 1);
        if (idx >= 0) check("t4_inject_chan", served_q[idx], 9);
        bad = 0;
        if (idx >= 0)
            for (int n = idx + 1; n < served_q.size(); n++)
                if (served_q[n] != (n - 1) % 16) bad++;
        check("t4_resume_order_errors", bad, 0);
        bad = 0;
        foreach (run_q[n]) if (run_q[n] != 1) bad++;
        check("t4_run_errors", bad, 0);
        check("t4_done_per_step", done_cnt - d0, served_q.size());
        check("t4_sel_rule_violations", viol, 0);
        base = rise_q.size();
        tick(20);
        check("t4_no_scan_after_disable", rise_q.size(), base);

        // Asynchronous reset in the middle of a long drive.
        push(12, 20);
        push(3, 5);
        b = 0;
        while (!i && b < 20) begin tick(); b++; end
        check("t5_drive_chan", int'(sel), 12);
        tick(3);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_i", int'(i), 0);
        check("t5_async_sel", int'(sel), 0);
        check("t5_async_count", int'(fifo_count), 0);
        check("t5_async_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        base = rise_q.size();
        tick(20);
        check("t5_quiet_after_reset", rise_q.size(), base);
        check("t5_busy_after_reset", int'(busy), 0);
        push(6, 2);
        wait_idle(50);
        check("t5_new_request_served", (served_q.size() > 0) ? served_q[served_q.size()-1] : -1, 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
